// File: rtl/pushbutton_debounce_array_pkg.sv
// pushbutton_debounce_array_pkg
//   Shared definitions for the multi-channel pushbutton conditioner:
//   - default debounce / repeat timings for the 100 MHz board clock
//   - clog2 helper used to size the per-channel counters
//   - params_legal(): parameter legality check evaluated at elaboration
package pushbutton_debounce_array_pkg;

  localparam int unsigned CLK_HZ                   = 100_000_000;
  localparam int unsigned DEF_CHANNELS             = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = CLK_HZ / 100; // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = CLK_HZ / 2;   // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = CLK_HZ / 10;  // 100 ms

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic bit params_legal(input int unsigned channels,
                                      input int unsigned debounce_cycles,
                                      input int unsigned repeat_delay_cycles,
                                      input int unsigned repeat_period_cycles);
    return (channels >= 1) && (debounce_cycles >= 2) &&
           (repeat_delay_cycles >= 2) && (repeat_period_cycles >= 2);
  endfunction

endpackage

// File: rtl/pushbutton_debounce_array_if.sv
// pushbutton_debounce_array_if
//   Button bundle between the board pins and the conditioner.
//   btn_in      raw asynchronous button inputs (one bit per channel)
//   btn_level   debounced level, 1 = pressed
//   btn_press   one-cycle pulse on accepted press and on each repeat
//   btn_release one-cycle pulse on accepted release
//   btn_held    1 while a button is held past the repeat delay
//   master: drives btn_in (board / bench side); slave: the conditioner.
interface pushbutton_debounce_array_if #(
  parameter int unsigned CHANNELS = 5
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_press;
  logic [CHANNELS-1:0] btn_release;
  logic [CHANNELS-1:0] btn_held;

  modport master (output btn_in,
                  input  btn_level, btn_press, btn_release, btn_held);
  modport slave  (input  btn_in,
                  output btn_level, btn_press, btn_release, btn_held);
endinterface

// File: rtl/pushbutton_debounce_array_debounce_channel.sv
// debounce_channel
//   One button: 2-FF synchroniser, restartable debounce counter, registered
//   level with press/release pulses, optional hold-to-repeat.
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_in       raw asynchronous button input
//   btn_level    debounced level (1 = pressed)
//   btn_press    one-cycle pulse on accepted press and on each repeat
//   btn_release  one-cycle pulse on accepted release
//   btn_held     1 while held past REPEAT_DELAY_CYCLES (0 if REPEAT_EN=0)
module debounce_channel
  import pushbutton_debounce_array_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW_IN        = 0,
  parameter int unsigned REPEAT_EN            = 0,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_held
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic INV = (ACTIVE_LOW_IN != 0);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rep_fire;

  // Synchroniser and debounce: a disagreeing sample must persist for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    s1_d    = btn_in ^ INV;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = s2_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Pulses are registered on the same edge that updates the level.
  always_comb begin
    press_d   = (level_d & ~level_q) | rep_fire;
    release_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int unsigned HC_W = clog2(REPEAT_DELAY_CYCLES + 1);
    localparam int unsigned PH_W = clog2(REPEAT_PERIOD_CYCLES);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_SAT  = HC_W'(REPEAT_DELAY_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            held_q, held_d;
    logic            fire;

    // Gating on level_d means the release edge clears everything and can
    // never also fire a repeat.
    always_comb begin
      hc_d   = hc_q;
      ph_d   = ph_q;
      held_d = held_q;
      fire   = 1'b0;
      if (!level_d || !level_q) begin
        hc_d   = '0;
        ph_d   = '0;
        held_d = 1'b0;
      end else if (!held_q) begin
        if (hc_q == HC_LAST) begin
          fire   = 1'b1;
          held_d = 1'b1;
          hc_d   = HC_SAT;
          ph_d   = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end else if (ph_q == PH_LAST) begin
        fire = 1'b1;
        ph_d = '0;
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hc_q   <= '0;
        ph_q   <= '0;
        held_q <= 1'b0;
      end else begin
        hc_q   <= hc_d;
        ph_q   <= ph_d;
        held_q <= held_d;
      end
    end

    assign rep_fire = fire;
    assign btn_held = held_q;
  end else begin : g_no_repeat
    assign rep_fire = 1'b0;
    assign btn_held = 1'b0;
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/pushbutton_debounce_array.sv
// pushbutton_debounce_array
//   CHANNELS independent pushbutton conditioners (synchronise, debounce,
//   press/release pulses, optional hold-to-repeat).
//   clk  system clock (only clock)
//   rst  asynchronous active-low reset
//   bus  pushbutton_debounce_array_if.slave: btn_in in; btn_level,
//        btn_press, btn_release, btn_held out (one bit per channel)
module pushbutton_debounce_array
  import pushbutton_debounce_array_pkg::*;
#(
  parameter int unsigned CHANNELS             = DEF_CHANNELS,
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ACTIVE_LOW_IN        = 0,
  parameter int unsigned REPEAT_EN            = 0,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  pushbutton_debounce_array_if.slave   bus
);

  if (!params_legal(CHANNELS, DEBOUNCE_CYCLES,
                    REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) begin : g_param_check
    $error("pushbutton_debounce_array: illegal parameters (CHANNELS>=1, cycle counts >=2)");
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .ACTIVE_LOW_IN        (ACTIVE_LOW_IN),
      .REPEAT_EN            (REPEAT_EN),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (bus.btn_in[g]),
      .btn_level   (bus.btn_level[g]),
      .btn_press   (bus.btn_press[g]),
      .btn_release (bus.btn_release[g]),
      .btn_held    (bus.btn_held[g])
    );
  end

endmodule

// File: tb/tb_pushbutton_debounce_array.sv
// tb_pushbutton_debounce_array
//   Two instances share one stimulus: u_rep (REPEAT_EN=1, active-high
//   inputs) and u_norep (REPEAT_EN=0, ACTIVE_LOW_IN=1, fed inverted pins).
//   A behavioural model derived from the timing rules (consecutive
//   disagreeing samples, time since acceptance) is compared every cycle.
module tb_pushbutton_debounce_array;

  localparam int CH = 2;
  localparam int D  = 4;
  localparam int R  = 10;
  localparam int P  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] btn = '0;

  always #5 clk = ~clk;

  pushbutton_debounce_array_if #(.CHANNELS(CH)) bus_r ();
  pushbutton_debounce_array_if #(.CHANNELS(CH)) bus_n ();

  assign bus_r.btn_in = btn;
  assign bus_n.btn_in = ~btn;

  pushbutton_debounce_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(0), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(R), .REPEAT_PERIOD_CYCLES(P)
  ) u_rep (.clk(clk), .rst(rst), .bus(bus_r));

  pushbutton_debounce_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(R), .REPEAT_PERIOD_CYCLES(P)
  ) u_norep (.clk(clk), .rst(rst), .bus(bus_n));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            edge_no = 0;
  logic [CH-1:0] m_d1 = '0, m_d2 = '0, m_lvl = '0;
  logic [CH-1:0] m_press_r = '0, m_press_n = '0, m_rel = '0, m_held_r = '0;
  int            m_run [CH];
  int            m_acc [CH];

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0;
    m_press_r = '0; m_press_n = '0; m_rel = '0; m_held_r = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_acc[c] = 0;
    end
  endtask

  task automatic model_step();
    edge_no++;
    for (int c = 0; c < CH; c++) begin
      logic s, nl;
      int t;
      s  = m_d2[c];
      nl = m_lvl[c];
      m_press_n[c] = 1'b0;
      m_rel[c]     = 1'b0;
      if (s != m_lvl[c]) m_run[c]++;
      else               m_run[c] = 0;
      if (m_run[c] == D) begin
        nl = s;
        m_run[c] = 0;
        if (nl) begin
          m_press_n[c] = 1'b1;
          m_acc[c]     = edge_no;
        end else begin
          m_rel[c] = 1'b1;
        end
      end
      m_press_r[c] = m_press_n[c];
      m_held_r[c]  = 1'b0;
      if (nl) begin
        t = edge_no - m_acc[c];
        m_held_r[c] = (t >= R);
        if (t == R || (t > R && ((t - R) % P) == 0)) m_press_r[c] = 1'b1;
      end
      m_d2[c]  = m_d1[c];
      m_d1[c]  = btn[c];
      m_lvl[c] = nl;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("rep.level",     bus_r.btn_level,   m_lvl);
      check("rep.press",     bus_r.btn_press,   m_press_r);
      check("rep.release",   bus_r.btn_release, m_rel);
      check("rep.held",      bus_r.btn_held,    m_held_r);
      check("norep.level",   bus_n.btn_level,   m_lvl);
      check("norep.press",   bus_n.btn_press,   m_press_n);
      check("norep.release", bus_n.btn_release, m_rel);
      check("norep.held",    bus_n.btn_held,    '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_btn(input logic [CH-1:0] v);
    @(posedge clk);
    #1 btn = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hold [CH];

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset.level", bus_r.btn_level, 2'b00);
    check("reset.press", bus_r.btn_press, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(3);

    // Clean press on channel 0.
    set_btn(2'b01);
    step(5);
    check("press.edge5.level", bus_r.btn_level, 2'b00);
    step(1);
    check("press.edge6.level", bus_r.btn_level, 2'b01);
    check("press.edge6.press", bus_r.btn_press, 2'b01);
    check("press.edge6.rel",   bus_r.btn_release, 2'b00);
    step(1);
    check("press.edge7.press", bus_r.btn_press, 2'b00);

    // Hold-to-repeat: now at acceptance+1.
    step(8);
    check("rep.a9.press", bus_r.btn_press, 2'b00);
    check("rep.a9.held",  bus_r.btn_held,  2'b00);
    step(1);
    check("rep.a10.press", bus_r.btn_press, 2'b01);
    check("rep.a10.held",  bus_r.btn_held,  2'b01);
    check("norep.a10.press", bus_n.btn_press, 2'b00);
    step(1);
    check("rep.a11.press", bus_r.btn_press, 2'b00);
    step(2);
    check("rep.a13.press", bus_r.btn_press, 2'b01);
    step(17);
    set_btn(2'b00);
    step(5);
    check("rel.edge5.level", bus_r.btn_level, 2'b01);
    step(1);
    check("rel.edge6.level", bus_r.btn_level,   2'b00);
    check("rel.edge6.rel",   bus_r.btn_release, 2'b01);
    check("rel.edge6.held",  bus_r.btn_held,    2'b00);
    check("rel.edge6.press", bus_r.btn_press,   2'b00);
    step(6);

    // Glitch: three cycles high.
    set_btn(2'b01);
    step(2);
    set_btn(2'b00);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch.level", bus_r.btn_level, 2'b00);
      check("glitch.press", bus_r.btn_press, 2'b00);
    end

    // Bounce 1,0,1,0 two cycles each, then stay 1.
    set_btn(2'b01); step(1);
    set_btn(2'b00); step(1);
    set_btn(2'b01); step(1);
    set_btn(2'b00); step(1);
    set_btn(2'b01);
    step(5);
    check("bounce.edge5.level", bus_r.btn_level, 2'b00);
    step(1);
    check("bounce.edge6.level", bus_r.btn_level, 2'b01);
    check("bounce.edge6.press", bus_r.btn_press, 2'b01);

    // Release channel 0 while pressing channel 1.
    set_btn(2'b10);
    step(5);
    check("swap.edge5.level", bus_r.btn_level, 2'b01);
    step(1);
    check("swap.edge6.level", bus_r.btn_level,   2'b10);
    check("swap.edge6.press", bus_r.btn_press,   2'b10);
    check("swap.edge6.rel",   bus_r.btn_release, 2'b01);

    // Async reset with both buttons held.
    set_btn(2'b11);
    step(6);
    check("hold.level", bus_r.btn_level, 2'b11);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("areset.rep.level",   bus_r.btn_level,   2'b00);
    check("areset.rep.press",   bus_r.btn_press,   2'b00);
    check("areset.rep.release", bus_r.btn_release, 2'b00);
    check("areset.rep.held",    bus_r.btn_held,    2'b00);
    check("areset.norep.level", bus_n.btn_level,   2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(5);
    check("rerelease.edge5.level", bus_r.btn_level, 2'b00);
    step(1);
    check("rerelease.edge6.level", bus_r.btn_level, 2'b11);
    check("rerelease.edge6.press", bus_r.btn_press, 2'b11);
    check("rerelease.norep.press", bus_n.btn_press, 2'b11);

    // Randomised run-length stimulus with occasional async resets.
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          btn[c] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 0) hold[c] = int'($urandom_range(1, 5));
          else                           hold[c] = int'($urandom_range(4, 40));
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end
    end

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pushbutton_debounce_array.md
Name: pushbutton_debounce_array

Overview:
- Parametrised multi-channel successor to the single-button pushbutton conditioner feeding the multiplier's control FSM (start/load/display-select buttons).
- Per channel: 2-FF synchroniser, restartable debounce counter, and registered level plus one-cycle press/release pulses.
- Optional hold-to-repeat mode emits periodic press pulses while a button stays down, for stepping operand/display selection.

Parameters:
- CHANNELS, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range >= 2, elaboration error otherwise.
- ACTIVE_LOW_IN, 0, 1 = raw input is inverted before synchronisation.
- REPEAT_EN, 0, 1 = enable hold/auto-repeat logic.
- REPEAT_DELAY_CYCLES, 50_000_000, cycles after accepted press before first repeat; >= 2.
- REPEAT_PERIOD_CYCLES, 10_000_000, cycles between subsequent repeats; >= 2.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  asynchronous, active-low reset.
- btn_in  input  CHANNELS  raw asynchronous button inputs.
- btn_level  output  CHANNELS  debounced level, 1 = pressed.
- btn_press  output  CHANNELS  one-cycle pulse on accepted press and on each repeat.
- btn_release  output  CHANNELS  one-cycle pulse on accepted release.
- btn_held  output  CHANNELS  1 while the button is held past REPEAT_DELAY_CYCLES; constant 0 when REPEAT_EN=0.

Behaviour:
- Reset (rst=0, async): sync stages, counters, btn_level, btn_press, btn_release and btn_held all go 0 immediately. Reset value corresponds to "released", after any ACTIVE_LOW_IN inversion.
- Synchroniser: s1 <= in ^ ACTIVE_LOW_IN; s2 <= s1.
- Debounce counter, evaluated on each edge:
  - s2 == level: cnt <= 0.
  - s2 != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != level and cnt == DEBOUNCE_CYCLES-1: level <= s2; cnt <= 0.
  - Any return to agreement before acceptance restarts the count from 0.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Latency: counting the first edge that samples the new btn_in value as edge 1, btn_level changes on edge DEBOUNCE_CYCLES+2.
- Pulses (all outputs registered):
  - btn_press is 1 for exactly the cycle following the edge at which level goes 0->1.
  - btn_release is 1 for exactly the cycle following the edge at which level goes 1->0.
  - Both are 0 otherwise, and never asserted together on one channel.
- Repeat (REPEAT_EN=1), per channel:
  - Hold counter hc <= 0 on the accepting press edge, then increments each cycle while level=1.
  - When hc reaches REPEAT_DELAY_CYCLES: btn_held <= 1, btn_press pulses for 1 cycle, and the phase counter clears.
  - Thereafter btn_press pulses every REPEAT_PERIOD_CYCLES cycles.
  - On release (level 1->0): hc, phase and btn_held clear on the same edge; no repeat pulse can follow a release pulse.
  - Counters saturate and never wrap.
- With REPEAT_EN=0, hold logic is not generated; btn_held = 0.
- Channels are fully independent; simultaneous events on different channels produce simultaneous pulses.
- Reset mid-operation: a button still held when rst deasserts is treated as a new press, with btn_press after DEBOUNCE_CYCLES+2 edges.
- Deasserted reset during a debounce count resumes nothing; counting starts fresh.

Decomposition:
- Shared package: clog2 function, DEBOUNCE/REPEAT default constants (per-board clock frequency), and the parameter legality checks.
- Natural sub-module: debounce_channel (sync + debounce + pulse + repeat for one bit), instantiated CHANNELS times in a generate loop. The top level only concatenates outputs.

Test Plan:
Bench parameters: CHANNELS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3.
- Clean press: btn_in[0] 0->1 and held. Required: btn_level[0] rises on edge 6; btn_press[0]=1 for exactly one cycle; btn_release and channel 1 stay 0.
- Glitch: btn_in[0] high for 3 cycles, then low. Required: btn_level[0], btn_press[0] and btn_release[0] remain 0 throughout.
- Bounce: btn_in[0] toggles 1,0,1,0 every 2 cycles, then stays 1. Required: exactly one btn_press[0] pulse, btn_level rising 6 edges after the final 0->1.
- Release: from accepted press, btn_in[0] -> 0. Required: btn_level[0] falls on edge 6 and btn_release[0] pulses once. Simultaneously pressing btn_in[1] must yield an independent press pulse with the same latency.
- Repeat (REPEAT_EN=1): hold btn_in[0] for 30 cycles past acceptance. Required: btn_press at acceptance, then at +10 (btn_held rises), +13, +16, ..., +28. On release, btn_held falls with btn_release and no further press pulses follow.
- Async reset: with btn_in[0] held and btn_level[0]=1, pulse rst=0 for 2 cycles. Required: all outputs 0 immediately, without waiting for a clock edge. After rst=1, btn_press[0] pulses again on edge 6.
